// File: rtl/eth_sw_arb_pkg.sv
// Shared definitions for the Ethernet switch egress arbiter.
// Contents:
//   ARB_NUM_DEF   - default number of requesting queues
//   MAX_ARB       - widest request vector the index helper handles
//   arb_state_e   - packet arbiter FSM states (IDLE, BUSY)
//   onehot_to_idx - binary index of a one-hot vector
package eth_sw_arb_pkg;

    localparam int ARB_NUM_DEF = 8;
    localparam int MAX_ARB     = 32;
    localparam int MAX_IDX_W   = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Returns the position of the set bit.
    // An all-zero input returns 0.
    // Callers zero-extend their vector to MAX_ARB bits and then narrow the result.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_ARB-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = {MAX_IDX_W{1'b0}};
        for (int i = 0; i < MAX_ARB; i++) begin
            idx = idx | (oh[i] ? MAX_IDX_W'(i) : {MAX_IDX_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational wrap-around round-robin picker.
// Selects the first set request bit scanning upward from ptr+1, wrapping to bit 0.
// Ports:
//   req      - request vector (ARB_NUM bits)
//   ptr      - index of the previous winner
//   pick_oh  - one-hot winner (all zero when req is zero)
//   pick_idx - binary index of the winner
// ARB_NUM must not exceed eth_sw_arb_pkg::MAX_ARB.
module rr_prio_pick
    import eth_sw_arb_pkg::*;
#(
    parameter int ARB_NUM = ARB_NUM_DEF,
    parameter int IDX_W   = $clog2(ARB_NUM)
) (
    input  logic [ARB_NUM-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [ARB_NUM-1:0] pick_oh,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [ARB_NUM-1:0] mask_s;
    logic [ARB_NUM-1:0] masked_s;
    logic [ARB_NUM-1:0] masked_oh_s;
    logic [ARB_NUM-1:0] unmasked_oh_s;

    // Thermometer mask of the positions strictly above the previous winner.
    always_comb begin
        mask_s = {ARB_NUM{1'b0}};
        for (int i = 0; i < ARB_NUM; i++) begin
            mask_s[i] = (IDX_W'(i) > ptr);
        end
    end

    assign masked_s = req & mask_s;

    // x & -x isolates the lowest set bit.
    assign masked_oh_s   = masked_s & (~masked_s + ARB_NUM'(1'b1));
    assign unmasked_oh_s = req & (~req + ARB_NUM'(1'b1));

    // When nothing is requested above the pointer, the scan wraps.
    // The wrapped winner is then the lowest requester overall.
    assign pick_oh  = (|masked_s) ? masked_oh_s : unmasked_oh_s;
    assign pick_idx = IDX_W'(onehot_to_idx(MAX_ARB'(pick_oh)));

endmodule

// File: rtl/rr_pkt_arbiter.sv
// Packet-level round-robin arbiter for the egress read path.
// A grant is held from the decision edge until the downstream read signals end of packet.
// Ports:
//   iClk      - clock; all state updates on the rising edge
//   iRst_n    - asynchronous active-low reset
//   iReq      - per-queue requests (already weight-gated)
//   iRdy      - read path can accept a new packet grant
//   iEop      - read of the granted packet completes this cycle
//   oGnt      - one-hot grant, held for the whole packet
//   oGntPulse - one-cycle copy of oGnt in the first grant cycle (charges one weight unit)
//   oGntValid - a grant is active
//   oGntIdx   - binary index of the active grant
module rr_pkt_arbiter
    import eth_sw_arb_pkg::*;
#(
    parameter int ARB_NUM = ARB_NUM_DEF,
    parameter int IDX_W   = $clog2(ARB_NUM)
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic [ARB_NUM-1:0] iReq,
    input  logic               iRdy,
    input  logic               iEop,
    output logic [ARB_NUM-1:0] oGnt,
    output logic [ARB_NUM-1:0] oGntPulse,
    output logic               oGntValid,
    output logic [IDX_W-1:0]   oGntIdx
);

    arb_state_e         state_q, state_d;
    logic [ARB_NUM-1:0] gnt_q, gnt_d;
    logic [ARB_NUM-1:0] pulse_q, pulse_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;

    logic [ARB_NUM-1:0] pick_req_s;
    logic [ARB_NUM-1:0] pick_oh_s;
    logic [IDX_W-1:0]   pick_idx_s;

    // The current holder is excluded from the scan.
    // In IDLE gnt_q is zero, so every request is eligible.
    // At a back-to-back decision, a lone re-requester falls back to IDLE and
    // is picked again one cycle later.
    assign pick_req_s = iReq & ~gnt_q;

    rr_prio_pick #(
        .ARB_NUM (ARB_NUM),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (pick_req_s),
        .ptr      (last_ptr_q),
        .pick_oh  (pick_oh_s),
        .pick_idx (pick_idx_s)
    );

    // Next-state and next-output logic.
    // iRdy and iReq matter only at decision points (IDLE, or BUSY with iEop).
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        pulse_d    = {ARB_NUM{1'b0}};
        valid_d    = valid_q;
        idx_d      = idx_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            IDLE: begin
                if (iRdy && (|pick_req_s)) begin
                    state_d    = BUSY;
                    gnt_d      = pick_oh_s;
                    pulse_d    = pick_oh_s;
                    valid_d    = 1'b1;
                    idx_d      = pick_idx_s;
                    last_ptr_d = pick_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (iEop) begin
                    if (iRdy && (|pick_req_s)) begin
                        state_d    = BUSY;
                        gnt_d      = pick_oh_s;
                        pulse_d    = pick_oh_s;
                        valid_d    = 1'b1;
                        idx_d      = pick_idx_s;
                        last_ptr_d = pick_idx_s;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = {ARB_NUM{1'b0}};
                        valid_d = 1'b0;
                        idx_d   = {IDX_W{1'b0}};
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = {ARB_NUM{1'b0}};
                valid_d = 1'b0;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    // The pointer resets to the top index so queue 0 wins first.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= IDLE;
            gnt_q      <= {ARB_NUM{1'b0}};
            pulse_q    <= {ARB_NUM{1'b0}};
            valid_q    <= 1'b0;
            idx_q      <= {IDX_W{1'b0}};
            last_ptr_q <= IDX_W'(ARB_NUM - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            pulse_q    <= pulse_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    assign oGnt      = gnt_q;
    assign oGntPulse = pulse_q;
    assign oGntValid = valid_q;
    assign oGntIdx   = idx_q;

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Directed self-checking bench for rr_pkt_arbiter (ARB_NUM = 8).
module tb_rr_pkt_arbiter;

    logic       iClk;
    logic       iRst_n;
    logic [7:0] iReq;
    logic       iRdy;
    logic       iEop;
    logic [7:0] oGnt;
    logic [7:0] oGntPulse;
    logic       oGntValid;
    logic [2:0] oGntIdx;

    int tests;
    int fails;

    rr_pkt_arbiter #(.ARB_NUM(8), .IDX_W(3)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iReq      (iReq),
        .iRdy      (iRdy),
        .iEop      (iEop),
        .oGnt      (oGnt),
        .oGntPulse (oGntPulse),
        .oGntValid (oGntValid),
        .oGntIdx   (oGntIdx)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Advance past one rising edge; outputs then show that edge's result.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst_n = 1'b0;
        iReq   = 8'h00;
        iRdy   = 1'b0;
        iEop   = 1'b0;
        repeat (2) step();
        iRst_n = 1'b1;
    endtask

    // Ends the current packet with no further requests and returns to IDLE.
    task automatic close_packet();
        iReq = 8'h00;
        iEop = 1'b1;
        step();
        iEop = 1'b0;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        iReq   = 8'hFF;
        iRdy   = 1'b1;
        iEop   = 1'b0;
        repeat (2) step();
        tests++; if (oGnt !== 8'h00)     begin fails++; $display("FAIL reset_gnt: got %h exp 00", oGnt); end
        tests++; if (oGntPulse !== 8'h00) begin fails++; $display("FAIL reset_pulse: got %h exp 00", oGntPulse); end
        tests++; if (oGntValid !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b exp 0", oGntValid); end
        tests++; if (oGntIdx !== 3'd0)    begin fails++; $display("FAIL reset_idx: got %0d exp 0", oGntIdx); end
    endtask

    task automatic test_single();
        // The first edge with reset released decides the grant.
        iRst_n = 1'b1;
        iReq   = 8'h01;
        iRdy   = 1'b1;
        step();
        tests++; if (oGnt !== 8'h01)      begin fails++; $display("FAIL single_gnt: got %h exp 01", oGnt); end
        tests++; if (oGntPulse !== 8'h01) begin fails++; $display("FAIL single_pulse: got %h exp 01", oGntPulse); end
        tests++; if (oGntIdx !== 3'd0)    begin fails++; $display("FAIL single_idx: got %0d exp 0", oGntIdx); end
        tests++; if (oGntValid !== 1'b1)  begin fails++; $display("FAIL single_valid: got %b exp 1", oGntValid); end
        step();
        tests++; if (oGnt !== 8'h01)      begin fails++; $display("FAIL single_hold: got %h exp 01", oGnt); end
        tests++; if (oGntPulse !== 8'h00) begin fails++; $display("FAIL single_pulse_clr: got %h exp 00", oGntPulse); end
        close_packet();
        tests++; if (oGntValid !== 1'b0)  begin fails++; $display("FAIL single_idle: got %b exp 0", oGntValid); end
        // iEop in IDLE with no requests must leave the arbiter idle.
        iEop = 1'b1;
        step();
        iEop = 1'b0;
        tests++; if (oGnt !== 8'h00)      begin fails++; $display("FAIL idle_eop_ignored: got %h exp 00", oGnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_oh;
        do_reset();
        iReq = 8'hFF;
        iRdy = 1'b1;
        iEop = 1'b0;
        step();
        for (int k = 0; k < 9; k++) begin
            exp_oh = 8'h01 << (k % 8);
            tests++; if (oGnt !== exp_oh)      begin fails++; $display("FAIL b2b_gnt[%0d]: got %h exp %h", k, oGnt, exp_oh); end
            tests++; if (oGntPulse !== exp_oh) begin fails++; $display("FAIL b2b_pulse[%0d]: got %h exp %h", k, oGntPulse, exp_oh); end
            tests++; if (oGntIdx !== 3'(k % 8)) begin fails++; $display("FAIL b2b_idx[%0d]: got %0d exp %0d", k, oGntIdx, k % 8); end
            for (int c = 2; c <= 4; c++) begin
                step();
                tests++;
                if (oGnt !== exp_oh || oGntPulse !== 8'h00 || oGntValid !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_hold[%0d.%0d]: got gnt=%h pulse=%h valid=%b exp gnt=%h pulse=00 valid=1",
                             k, c, oGnt, oGntPulse, oGntValid, exp_oh);
                end
            end
            iEop = 1'b1;
            step();
            iEop = 1'b0;
        end
        close_packet();
    endtask

    task automatic test_regrant_bubble();
        // The pointer sits at 0 from the previous test, so 3 is found by the upward scan.
        iReq = 8'h08;
        iRdy = 1'b1;
        step();
        tests++; if (oGnt !== 8'h08) begin fails++; $display("FAIL regrant_first: got %h exp 08", oGnt); end
        iEop = 1'b1;
        step();
        iEop = 1'b0;
        tests++;
        if (oGnt !== 8'h00 || oGntValid !== 1'b0 || oGntPulse !== 8'h00) begin
            fails++;
            $display("FAIL regrant_bubble: got gnt=%h valid=%b pulse=%h exp 00/0/00", oGnt, oGntValid, oGntPulse);
        end
        step();
        tests++; if (oGnt !== 8'h08)      begin fails++; $display("FAIL regrant_gnt: got %h exp 08", oGnt); end
        tests++; if (oGntPulse !== 8'h08) begin fails++; $display("FAIL regrant_pulse: got %h exp 08", oGntPulse); end
        close_packet();
    endtask

    task automatic test_drop_and_rdy();
        iReq = 8'h20;
        iRdy = 1'b1;
        step();
        tests++; if (oGntIdx !== 3'd5) begin fails++; $display("FAIL drop_idx: got %0d exp 5", oGntIdx); end
        // Request drops and iRdy falls mid-packet; neither may revoke the grant.
        iReq = 8'h00;
        iRdy = 1'b0;
        repeat (2) begin
            step();
            tests++;
            if (oGnt !== 8'h20 || oGntValid !== 1'b1 || oGntIdx !== 3'd5) begin
                fails++;
                $display("FAIL drop_hold: got gnt=%h valid=%b idx=%0d exp 20/1/5", oGnt, oGntValid, oGntIdx);
            end
        end
        iReq = 8'h20;
        iEop = 1'b1;
        step();
        iEop = 1'b0;
        tests++; if (oGntValid !== 1'b0) begin fails++; $display("FAIL drop_idle: got %b exp 0", oGntValid); end
        repeat (2) step();
        tests++; if (oGnt !== 8'h00) begin fails++; $display("FAIL drop_wait_rdy: got %h exp 00", oGnt); end
        iRdy = 1'b1;
        step();
        tests++; if (oGnt !== 8'h20)      begin fails++; $display("FAIL drop_regnt: got %h exp 20", oGnt); end
        tests++; if (oGntPulse !== 8'h20) begin fails++; $display("FAIL drop_regnt_pulse: got %h exp 20", oGntPulse); end
        close_packet();
    endtask

    task automatic test_async_reset();
        do_reset();
        iReq = 8'h40;
        iRdy = 1'b1;
        step();
        tests++; if (oGntIdx !== 3'd6) begin fails++; $display("FAIL areset_pre_idx: got %0d exp 6", oGntIdx); end
        step();
        // Assert reset between edges: outputs must clear without a clock edge.
        #2;
        iRst_n = 1'b0;
        #1;
        tests++;
        if (oGnt !== 8'h00 || oGntPulse !== 8'h00 || oGntValid !== 1'b0 || oGntIdx !== 3'd0) begin
            fails++;
            $display("FAIL areset_clear: got gnt=%h pulse=%h valid=%b idx=%0d exp all 0", oGnt, oGntPulse, oGntValid, oGntIdx);
        end
        step();
        iRst_n = 1'b1;
        iReq   = 8'hC0;
        step();
        tests++; if (oGnt !== 8'h40)      begin fails++; $display("FAIL areset_first_gnt: got %h exp 40", oGnt); end
        tests++; if (oGntPulse !== 8'h40) begin fails++; $display("FAIL areset_first_pulse: got %h exp 40", oGntPulse); end
        close_packet();
    endtask

    // Queue 0 has weight 2 and queue 1 has weight 1.
    // A small gate model drives iReq.
    // Credits reload when both queues are exhausted.
    task automatic test_wrr_ratio();
        int cr0, cr1, cnt0, cnt1, rounds;
        do_reset();
        cr0 = 2; cr1 = 1; cnt0 = 0; cnt1 = 0; rounds = 0;
        iRdy = 1'b1;
        iReq = 8'h03;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            if (oGntPulse[0]) begin cnt0++; cr0--; end
            if (oGntPulse[1]) begin cnt1++; cr1--; end
            if (cr0 <= 0 && cr1 <= 0) begin
                tests++;
                if (cnt0 != 2 || cnt1 != 1) begin
                    fails++;
                    $display("FAIL wrr_round[%0d]: got q0=%0d q1=%0d exp q0=2 q1=1", rounds, cnt0, cnt1);
                end
                rounds++;
                cnt0 = 0; cnt1 = 0; cr0 = 2; cr1 = 1;
            end
            iReq = {6'b000000, (cr1 > 0), (cr0 > 0)};
            iEop = oGntValid && (oGntPulse == 8'h00);
        end
        tests++; if (rounds < 3) begin fails++; $display("FAIL wrr_rounds: got %0d exp >=3", rounds); end
        close_packet();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        iRst_n = 1'b0;
        iReq   = 8'h00;
        iRdy   = 1'b0;
        iEop   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_regrant_bubble();
        test_drop_and_rdy();
        test_async_reset();
        test_wrr_ratio();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_pkt_arbiter.md
RR_PKT_ARBITER -- requirements
Module: rr_pkt_arbiter

Interface
REQ-001 Parameter ARB_NUM, default 8: number of requesting queues; must be 2 or more.
REQ-002 Parameter IDX_W, default $clog2(ARB_NUM): width of the grant index.
REQ-003 iClk  input  1  clock; all state updates on rising edge.
REQ-004 iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 iReq  input  ARB_NUM  per-queue requests, already weight-gated by WrrWeightGate (its oReq).
REQ-006 iRdy  input  1  downstream read path can accept a new packet grant.
REQ-007 iEop  input  1  downstream read of the currently granted packet completes this cycle.
REQ-008 oGnt  output  ARB_NUM  one-hot grant, held for the whole packet.
REQ-009 oGntPulse  output  ARB_NUM  one-cycle one-hot pulse per new grant; drives WrrWeightGate iGnt so each packet costs one weight unit.
REQ-010 oGntValid  output  1  a grant is active (state BUSY).
REQ-011 oGntIdx  output  IDX_W  binary index of the active grant.

Function
REQ-012 The FSM has two states. IDLE means no grant is active; BUSY means the grant is held until iEop.
REQ-013 IDLE transition: with iRdy=1 and |iReq=1, register a new grant and go to BUSY at the same edge; otherwise stay in IDLE.
REQ-014 Selection: choose the first set iReq bit scanning upward from (lastPtr+1) mod ARB_NUM, wrapping at ARB_NUM-1 to 0.
REQ-015 lastPtr updates to the selected index at the edge where the grant is registered.
REQ-016 Latency: a request sampled at edge N produces oGnt, oGntValid, oGntIdx and oGntPulse all registered at edge N, visible in cycle N+1.
REQ-017 oGntPulse is set only in the first grant cycle and is 0 in every other cycle.
REQ-018 In BUSY, oGnt and oGntIdx stay constant regardless of iReq; a request dropping mid-packet does not revoke the grant.
REQ-019 BUSY with iEop=1: if iRdy=1 and any iReq bit is set, excluding the current index, grant the next one in the same edge (back-to-back grant, with a new oGntPulse); otherwise clear the grant and go to IDLE.
REQ-020 Under the back-to-back rule the current index is excluded from the scan. If it is the only requester, the FSM returns to IDLE and the current index is re-granted one cycle later, which guarantees one bubble.
REQ-021 iEop in IDLE is ignored.
REQ-022 iRdy is sampled only at grant decisions; iRdy falling during BUSY has no effect.
REQ-023 oGnt is always zero or one-hot; oGntPulse is always a subset of oGnt.
REQ-024 Weight refresh in WrrWeightGate changes iReq combinationally; the arbiter reacts only at its next decision point.

Reset
REQ-025 Asserting iRst_n=0 sets state=IDLE, oGnt=0, oGntPulse=0, oGntValid=0, oGntIdx=0, lastPtr=ARB_NUM-1 (so index 0 has first priority).
REQ-026 Reset mid-packet drops the grant immediately, without waiting for iEop.
REQ-027 The first grant after reset deassertion is decided at the first edge with iRst_n=1.

Structure
REQ-028 Shared package eth_sw_arb_pkg holds the default ARB_NUM, the FSM state enum (IDLE, BUSY) and the onehot-to-index function.
REQ-029 A combinational sub-module rr_prio_pick (inputs: request vector, pointer; outputs: one-hot and index) performs the wrap-around scan.
REQ-030 rr_prio_pick uses the masked/unmasked double-priority method.
REQ-031 All outputs are driven directly from flops.

Verification
REQ-032 Reset, then iReq=8'h01, iRdy=1 -> next cycle oGnt=8'h01, oGntPulse=8'h01, oGntIdx=0; one cycle later oGntPulse=0 and oGnt=8'h01 is held.
REQ-033 iReq=8'hFF steady, iEop pulsed every 4 cycles -> grant order 0,1,2,...,7,0 with no idle cycles between packets.
REQ-034 Grant to index 3 active, iReq=8'h08 only, iEop=1 -> IDLE for one cycle, then index 3 is re-granted with a new pulse.
REQ-035 Grant to index 5 active, iReq[5] dropped to 0 mid-packet -> oGnt=8'h20 held until iEop; iRdy=0 at iEop -> IDLE, no grant until iRdy=1.
REQ-036 iRst_n asserted while BUSY with index 6 -> all outputs 0 asynchronously; after release with iReq=8'hC0 -> index 6 is granted first, since lastPtr was reset to 7.
REQ-037 Integrated with WrrWeightGate with weights {2,1,...}, queues 0 and 1 both requesting -> packet counts per refresh round are 2:1.
